// File: rtl/uart_rx_ext_pkg.sv
// Shared constants and helpers for the extended UART receiver:
// parity modes, 12 MHz baud divisors and the parity check function.
package uart_rx_ext_pkg;

    localparam int PAR_NONE = 32'd0;
    localparam int PAR_ODD  = 32'd1;
    localparam int PAR_EVEN = 32'd2;

    localparam int BAUD_300    = 32'd40000;
    localparam int BAUD_600    = 32'd20000;
    localparam int BAUD_1200   = 32'd10000;
    localparam int BAUD_2400   = 32'd5000;
    localparam int BAUD_4800   = 32'd2500;
    localparam int BAUD_9600   = 32'd1250;
    localparam int BAUD_19200  = 32'd625;
    localparam int BAUD_38400  = 32'd312;
    localparam int BAUD_57600  = 32'd208;
    localparam int BAUD_115200 = 32'd104;

    // Data is zero-extended to 9 bits; padding zeros do not change the XOR.
    function automatic logic parity_error(input logic [8:0] word, input logic par_bit,
                                          input int mode);
        logic odd_ones_s;
        odd_ones_s = ^{word, par_bit};
        case (mode)
            PAR_ODD:  return ~odd_ones_s;
            PAR_EVEN: return odd_ones_s;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Down-counting bit timer: reloads on load, ticks for one cycle at zero while enabled.
module uart_bit_timer #(
    parameter int BAUD = 104,
    parameter int CW   = $clog2(BAUD)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] load_val,
    input  logic          load,
    input  logic          en,
    output logic          tick
);

    localparam logic [CW-1:0] ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] ONE  = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] cnt_r;

    // Counter register: load has priority, then count down while enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= ZERO;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (en && (cnt_r != ZERO)) begin
            cnt_r <= cnt_r - ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tick = en && (cnt_r == ZERO);

endmodule

// File: rtl/uart_rx_ext.sv
// Configurable asynchronous serial receiver (5-9 data bits, none/odd/even parity,
// 1-2 stop bits) with glitch rejection, error/break flags and valid/ready output.
module uart_rx_ext
    import uart_rx_ext_pkg::*;
#(
    parameter int BAUD      = 104,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun,
    output logic                 busy
);

    localparam int              TW        = $clog2(BAUD);
    localparam logic [TW-1:0]   HALF_LOAD = TW'(BAUD / 2 - 1);
    localparam logic [TW-1:0]   FULL_LOAD = TW'(BAUD - 1);
    localparam logic [3:0]      LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic            LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_DONE      = 3'd5,
        S_WAIT_HIGH = 3'd6
    } state_t;

    state_t               state_r, state_nx_s;
    logic                 rx_meta_r, rx_sync_r, rx_s;
    logic                 tick_s, tmr_load_s, tmr_en_s;
    logic [TW-1:0]        tmr_val_s;
    logic                 shift_en_s, par_cap_s, stop_cap_s, bit_clr_s, done_s;
    logic [DATA_BITS-1:0] shift_r, data_r;
    logic [3:0]           bit_cnt_r;
    logic                 stop_cnt_r, par_bit_r, ferr_pend_r, first_stop_r;
    logic                 valid_r, parity_err_r, frame_err_r, break_r, overrun_r, busy_r;
    logic                 break_s;

    // Two-flop synchroniser on the asynchronous line, idling high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    assign rx_s = rx_sync_r;

    uart_bit_timer #(.BAUD(BAUD), .CW(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load_val (tmr_val_s),
        .load     (tmr_load_s),
        .en       (tmr_en_s),
        .tick     (tick_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state and per-state datapath strobes; every timed state reloads on its tick.
    always_comb begin
        state_nx_s = state_r;
        tmr_load_s = 1'b0;
        tmr_val_s  = FULL_LOAD;
        tmr_en_s   = 1'b0;
        shift_en_s = 1'b0;
        par_cap_s  = 1'b0;
        stop_cap_s = 1'b0;
        bit_clr_s  = 1'b0;
        done_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (!rx_s) begin
                    state_nx_s = S_START;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = HALF_LOAD;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_START: begin
                tmr_en_s = 1'b1;
                if (tick_s) begin
                    if (rx_s) begin
                        state_nx_s = S_IDLE;
                    end else begin
                        state_nx_s = S_DATA;
                        tmr_load_s = 1'b1;
                        bit_clr_s  = 1'b1;
                    end
                end else begin
                    state_nx_s = S_START;
                end
            end
            S_DATA: begin
                tmr_en_s = 1'b1;
                if (tick_s) begin
                    shift_en_s = 1'b1;
                    tmr_load_s = 1'b1;
                    if (bit_cnt_r == LAST_BIT) begin
                        state_nx_s = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                    end else begin
                        state_nx_s = S_DATA;
                    end
                end else begin
                    state_nx_s = S_DATA;
                end
            end
            S_PARITY: begin
                tmr_en_s = 1'b1;
                if (tick_s) begin
                    par_cap_s  = 1'b1;
                    tmr_load_s = 1'b1;
                    state_nx_s = S_STOP;
                end else begin
                    state_nx_s = S_PARITY;
                end
            end
            S_STOP: begin
                tmr_en_s = 1'b1;
                if (tick_s) begin
                    stop_cap_s = 1'b1;
                    if (stop_cnt_r == LAST_STOP) begin
                        state_nx_s = S_DONE;
                    end else begin
                        tmr_load_s = 1'b1;
                        state_nx_s = S_STOP;
                    end
                end else begin
                    state_nx_s = S_STOP;
                end
            end
            S_DONE: begin
                done_s     = 1'b1;
                state_nx_s = rx_s ? S_IDLE : S_WAIT_HIGH;
            end
            S_WAIT_HIGH: begin
                if (rx_s) begin
                    state_nx_s = S_IDLE;
                end else begin
                    state_nx_s = S_WAIT_HIGH;
                end
            end
            default: begin
                state_nx_s = S_IDLE;
            end
        endcase
    end

    // Frame capture: shift register (LSB arrives first), parity bit, stop-bit status.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_r      <= {DATA_BITS{1'b0}};
            bit_cnt_r    <= 4'd0;
            stop_cnt_r   <= 1'b0;
            par_bit_r    <= 1'b0;
            ferr_pend_r  <= 1'b0;
            first_stop_r <= 1'b1;
        end else if (bit_clr_s) begin
            bit_cnt_r   <= 4'd0;
            stop_cnt_r  <= 1'b0;
            ferr_pend_r <= 1'b0;
        end else begin
            if (shift_en_s) begin
                shift_r   <= {rx_s, shift_r[DATA_BITS-1:1]};
                bit_cnt_r <= bit_cnt_r + 4'd1;
            end
            if (par_cap_s) begin
                par_bit_r <= rx_s;
            end
            if (stop_cap_s) begin
                stop_cnt_r <= ~stop_cnt_r;
                if (!rx_s) begin
                    ferr_pend_r <= 1'b1;
                end
                if (stop_cnt_r == 1'b0) begin
                    first_stop_r <= rx_s;
                end
            end
        end
    end

    assign break_s = (shift_r == {DATA_BITS{1'b0}}) &&
                     ((PARITY == PAR_NONE) || !par_bit_r) && !first_stop_r;

    // Output word and flags; a fresh word always wins over an unconsumed one.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r       <= {DATA_BITS{1'b0}};
            valid_r      <= 1'b0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
            break_r      <= 1'b0;
            overrun_r    <= 1'b0;
        end else if (done_s) begin
            data_r       <= shift_r;
            valid_r      <= 1'b1;
            parity_err_r <= parity_error(9'(shift_r), par_bit_r, PARITY);
            frame_err_r  <= ferr_pend_r;
            break_r      <= break_s;
            overrun_r    <= valid_r && !ready;
        end else if (valid_r && ready) begin
            valid_r <= 1'b0;
        end
    end

    // Busy mirrors the state register being anywhere but idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (state_nx_s != S_IDLE);
        end
    end

    assign data       = data_r;
    assign valid      = valid_r;
    assign parity_err = parity_err_r;
    assign frame_err  = frame_err_r;
    assign break_det  = break_r;
    assign overrun    = overrun_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_uart_rx_ext.sv
// Scoreboard bench for uart_rx_ext: three frame formats (8N1, 8E1, 7O2) driven
// with directed and random frames, checked against a frame-level reference model.
module tb_uart_rx_ext;

    localparam int BAUD = 16;

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
        logic       ovr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_v[3];
    logic ready_v[3];
    logic valid_v[3], perr_v[3], ferr_v[3], brk_v[3], ovr_v[3], busy_v[3];
    logic [7:0] data0, data1;
    logic [6:0] data2;
    logic [8:0] data_v[3];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int start_cyc[3];
    int rise_cyc[3];
    exp_t q0[$], q1[$], q2[$];
    logic pvalid[3], pready[3];
    exp_t psnap[3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_ext #(.BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .rx(rx_v[0]), .data(data0), .valid(valid_v[0]),
        .ready(ready_v[0]), .parity_err(perr_v[0]), .frame_err(ferr_v[0]),
        .break_det(brk_v[0]), .overrun(ovr_v[0]), .busy(busy_v[0]));

    uart_rx_ext #(.BAUD(BAUD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst), .rx(rx_v[1]), .data(data1), .valid(valid_v[1]),
        .ready(ready_v[1]), .parity_err(perr_v[1]), .frame_err(ferr_v[1]),
        .break_det(brk_v[1]), .overrun(ovr_v[1]), .busy(busy_v[1]));

    uart_rx_ext #(.BAUD(BAUD), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_7o2 (
        .clk(clk), .rst(rst), .rx(rx_v[2]), .data(data2), .valid(valid_v[2]),
        .ready(ready_v[2]), .parity_err(perr_v[2]), .frame_err(ferr_v[2]),
        .break_det(brk_v[2]), .overrun(ovr_v[2]), .busy(busy_v[2]));

    always_comb begin
        data_v[0] = {1'b0, data0};
        data_v[1] = {1'b0, data1};
        data_v[2] = {2'b00, data2};
    end

    function automatic int dbits(input int i);
        return (i == 2) ? 7 : 8;
    endfunction

    function automatic int pmode(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 2 : 1);
    endfunction

    function automatic int sbits(input int i);
        return (i == 2) ? 2 : 1;
    endfunction

    function automatic logic [8:0] mask_word(input int i, input logic [8:0] word);
        logic [8:0] m;
        m = 9'((1 << dbits(i)) - 1);
        return word & m;
    endfunction

    // Parity bit a well-behaved transmitter would send.
    function automatic logic good_par(input int i, input logic [8:0] word);
        int ones;
        ones = $countones(mask_word(i, word));
        return (pmode(i) == 2) ? logic'(ones % 2) : logic'((ones + 1) % 2);
    endfunction

    // Frame-level reference: what the receiver must report for one transmitted frame.
    function automatic exp_t model(input int i, input logic [8:0] word, input logic par_bit,
                                   input logic [1:0] stops, input logic ovr);
        exp_t e;
        int ones;
        e.data = mask_word(i, word);
        ones = $countones(e.data) + int'(par_bit);
        if (pmode(i) == 2)      e.perr = (ones % 2) == 1;
        else if (pmode(i) == 1) e.perr = (ones % 2) == 0;
        else                    e.perr = 1'b0;
        e.ferr = !stops[0] || (sbits(i) == 2 && !stops[1]);
        e.brk  = (e.data == 9'd0) && (pmode(i) == 0 || !par_bit) && !stops[0];
        e.ovr  = ovr;
        return e;
    endfunction

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : ((i == 1) ? q1.size() : q2.size());
    endfunction

    task automatic push_exp(input int i, input exp_t e);
        case (i)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop_exp(input int i, output exp_t e);
        case (i)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one whole frame on line i; expected result goes to the scoreboard first.
    task automatic send_frame(input int i, input logic [8:0] word, input logic par_bit,
                              input logic [1:0] stops, input logic ovr);
        logic bits[$];
        push_exp(i, model(i, word, par_bit, stops, ovr));
        bits.push_back(1'b0);
        for (int b = 0; b < dbits(i); b++) bits.push_back(word[b]);
        if (pmode(i) != 0) bits.push_back(par_bit);
        for (int s = 0; s < sbits(i); s++) bits.push_back(stops[s]);
        start_cyc[i] = cyc;
        foreach (bits[k]) begin
            rx_v[i] = bits[k];
            idle(BAUD);
        end
        rx_v[i] = 1'b1;
    endtask

    task automatic rand_stream(input int i);
        logic [8:0] w;
        logic       p;
        logic [1:0] st;
        for (int n = 0; n < 10; n++) begin
            w  = 9'($urandom);
            p  = good_par(i, w) ^ ($urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b11;
            if ($urandom_range(0, 7) == 0) w = 9'd0;
            send_frame(i, w, p, st, 1'b0);
            idle(BAUD + $urandom_range(0, BAUD));
        end
    endtask

    // Monitor: a new word is valid rising, valid held across a handshake, or changed contents.
    always @(negedge clk) begin
        exp_t snap, e;
        for (int i = 0; i < 3; i++) begin
            snap = '{data: data_v[i], perr: perr_v[i], ferr: ferr_v[i], brk: brk_v[i], ovr: ovr_v[i]};
            if (rst) begin
                pvalid[i] = 1'b0;
                pready[i] = 1'b0;
            end else begin
                if (valid_v[i] && (!pvalid[i] || pready[i] || snap != psnap[i])) begin
                    if (!pvalid[i]) rise_cyc[i] = cyc;
                    n_checks++;
                    if (qsize(i) == 0) begin
                        n_errors++;
                        $display("FAIL word_inst%0d: unexpected word data=%h, none expected", i, snap.data);
                    end else begin
                        pop_exp(i, e);
                        if (snap !== e) begin
                            n_errors++;
                            $display("FAIL word_inst%0d: got data=%h p=%b f=%b b=%b o=%b, want data=%h p=%b f=%b b=%b o=%b",
                                     i, snap.data, snap.perr, snap.ferr, snap.brk, snap.ovr,
                                     e.data, e.perr, e.ferr, e.brk, e.ovr);
                        end
                    end
                end
                pvalid[i] = valid_v[i];
                pready[i] = ready_v[i];
            end
            psnap[i] = snap;
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            rx_v[i]    = 1'b1;
            ready_v[i] = 1'b1;
        end
        idle(3);
        rst = 1'b0;
        idle(2);
        check("rst_valid", 32'(valid_v[0]), 32'd0);
        check("rst_data", 32'(data0), 32'd0);
        check("rst_flags", 32'({perr_v[0], ferr_v[0], brk_v[0], ovr_v[0]}), 32'd0);
        check("rst_busy", 32'(busy_v[0]), 32'd0);

        // 8N1: latency, hold under backpressure, release.
        ready_v[0] = 1'b0;
        send_frame(0, 9'h055, 1'b0, 2'b11, 1'b0);
        check("latency_8n1", 32'(rise_cyc[0] - start_cyc[0]), 32'(4 + BAUD / 2 + BAUD * 9));
        idle(100);
        check("hold_valid", 32'(valid_v[0]), 32'd1);
        check("hold_data", 32'(data0), 32'h55);
        ready_v[0] = 1'b1;
        idle(1);
        check("release_valid", 32'(valid_v[0]), 32'd0);

        // 8E1 parity good then bad.
        send_frame(1, 9'h0A7, 1'b1, 2'b11, 1'b0);
        idle(BAUD);
        send_frame(1, 9'h0A7, 1'b0, 2'b11, 1'b0);
        idle(BAUD);
        check("perr_8e1", 32'(perr_v[1]), 32'd1);

        // 7O2: second stop low, then a long break yielding a single word.
        send_frame(2, 9'h03C, good_par(2, 9'h03C), 2'b01, 1'b0);
        idle(BAUD);
        check("ferr_7o2", 32'(ferr_v[2]), 32'd1);
        push_exp(2, model(2, 9'd0, 1'b0, 2'b00, 1'b0));
        rx_v[2] = 1'b0;
        idle(12 * BAUD);
        check("break_busy_low", 32'(busy_v[2]), 32'd1);
        rx_v[2] = 1'b1;
        idle(2 * BAUD);
        check("break_seen", 32'(qsize(2)), 32'd0);
        check("break_idle", 32'(busy_v[2]), 32'd0);
        send_frame(2, 9'h02A, good_par(2, 9'h02A), 2'b11, 1'b0);
        idle(BAUD);

        // Start-bit glitch shorter than half a bit.
        rx_v[0] = 1'b0;
        idle(5);
        rx_v[0] = 1'b1;
        @(negedge clk);
        check("glitch_busy", 32'(busy_v[0]), 32'd1);
        idle(20);
        check("glitch_idle", 32'(busy_v[0]), 32'd0);
        check("glitch_novalid", 32'(valid_v[0]), 32'd0);
        send_frame(0, 9'h081, 1'b0, 2'b11, 1'b0);
        idle(BAUD);

        // Overrun: back-to-back with no consumer.
        ready_v[0] = 1'b0;
        send_frame(0, 9'h011, 1'b0, 2'b11, 1'b0);
        send_frame(0, 9'h022, 1'b0, 2'b11, 1'b1);
        check("ovr_data", 32'(data0), 32'h22);
        check("ovr_flag", 32'(ovr_v[0]), 32'd1);
        ready_v[0] = 1'b1;
        idle(2);
        ready_v[0] = 1'b0;
        idle(BAUD);

        // Consume exactly on the second word's update cycle: no overrun.
        fork
            begin
                send_frame(0, 9'h011, 1'b0, 2'b11, 1'b0);
                send_frame(0, 9'h022, 1'b0, 2'b11, 1'b0);
            end
            begin
                repeat (BAUD * 10 + 3 + BAUD / 2 + BAUD * 9) @(posedge clk);
                #1 ready_v[0] = 1'b1;
                @(posedge clk);
                #1 ready_v[0] = 1'b0;
            end
        join
        check("same_cycle_valid", 32'(valid_v[0]), 32'd1);
        check("same_cycle_data", 32'(data0), 32'h22);
        check("same_cycle_ovr", 32'(ovr_v[0]), 32'd0);
        ready_v[0] = 1'b1;
        idle(2);

        // Reset in the middle of the data bits of 0xF0.
        rx_v[0] = 1'b0;
        idle(5 * BAUD);
        rst = 1'b1;
        rx_v[0] = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(1);
        check("midrst_valid", 32'(valid_v[0]), 32'd0);
        check("midrst_data", 32'(data0), 32'd0);
        check("midrst_flags", 32'({perr_v[0], ferr_v[0], brk_v[0], ovr_v[0]}), 32'd0);
        check("midrst_busy", 32'(busy_v[0]), 32'd0);
        send_frame(0, 9'h00F, 1'b0, 2'b11, 1'b0);
        idle(BAUD);

        // Random frames on all three formats concurrently.
        fork
            rand_stream(0);
            rand_stream(1);
            rand_stream(2);
        join
        idle(2 * BAUD);
        for (int i = 0; i < 3; i++) check($sformatf("drain_inst%0d", i), 32'(qsize(i)), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
